vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA timing from CLOCK_50 using an internal divide-by-2 pixel enable.
- Presents pixel coordinates upstream to the pixel/colour logic, which is driven by SW/KEY.
- Registers the returned colour onto the ADV7123 DAC pins VGA_R/G/B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N and VGA_CLK.
- Sits between the colour-generation logic and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
CLOCK_50  in  1  system clock, 50 MHz; the only clock
reset  in  1  asynchronous, active-high reset
rgb_in  in  24  colour for current pixel_x/pixel_y, {R[23:16],G[15:8],B[7:0]}
pixel_x  out  10  current horizontal count
pixel_y  out  10  current vertical count
pixel_valid  out  1  current count is inside the active area
frame_start  out  1  one-CLOCK_50 pulse at start of each frame
VGA_CLK  out  1  pixel clock to DAC, 25 MHz
VGA_HS  out  1  horizontal sync, active low
VGA_VS  out  1  vertical sync, active low
VGA_BLANK_N  out  1  low during blanking
VGA_SYNC_N  out  1  held 0 (sync-on-green unused)
VGA_R  out  8  red to DAC
VGA_G  out  8  green to DAC
VGA_B  out  8  blue to DAC

Behaviour:
- Derived constants: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
- Reset (async, while high):
  - div=0, h=0, v=0.
  - VGA_CLK=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_SYNC_N=0, VGA_R/G/B=0.
- Divider:
  - div toggles on every CLOCK_50 edge.
  - pix_en = (div==1).
  - VGA_CLK = div (registered), so the DAC rising edge falls mid-data.
- Counters advance only on edges where pix_en=1:
  - h increments; when h==H_TOTAL-1 it wraps to 0 and v increments.
  - When v==V_TOTAL-1 and h wraps, v wraps to 0.
  - Counters hold between pix_en edges, so each count lasts exactly 2 CLOCK_50 cycles.
- Combinational upstream outputs:
  - pixel_x=h, pixel_y=v.
  - pixel_valid = (h<H_ACTIVE)&&(v<V_ACTIVE).
  - frame_start = pix_en && h==0 && v==0. After reset release this is the second cycle; thereafter once per 840000 cycles.
- Registered pin outputs, updated on pix_en edges from the current h/v/rgb_in:
  - VGA_HS <= ~(H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC), i.e. low for h 656..751.
  - VGA_VS <= ~(V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC), i.e. low for v 490..491.
  - VGA_BLANK_N <= pixel_valid.
  - VGA_R/G/B <= pixel_valid ? rgb_in fields : 0.
- Latency:
  - Pins reflect count (x,y) one pixel period (2 CLOCK_50) after that count is presented.
  - Upstream must hold rgb_in valid combinationally, or with ≤1 CLOCK_50 of latency, for the presented coordinate.
  - rgb_in is sampled only on pix_en edges; changes between edges are ignored.
- Blanking: RGB is forced to 0 outside the active area regardless of rgb_in.
- Reset mid-frame: all state returns to reset values immediately; the frame restarts at (0,0) after release, with no partial-line catch-up.
- VGA_SYNC_N is constant 0 in all states.

Test Plan:
- Reset held 100 ns -> all pin outputs at reset values. After release: frame_start high on the 2nd edge; pixel_x=0, pixel_y=0; VGA_CLK toggles with a 40 ns period.
- Free-run one line -> VGA_HS period 1600 CLOCK_50 (32 µs), low for exactly 192 cycles; falling edge 2 cycles after pixel_x changes to 656.
- Free-run one frame -> VGA_VS period 840000 cycles (16.8 ms), low for 3200 cycles starting when pixel_y reaches 490; frame_start pulses exactly once per frame.
- rgb_in=24'hFF0000 constant:
  - VGA_R=8'hFF and VGA_BLANK_N=1 for 1280 cycles per active line.
  - VGA_R=0 and BLANK_N=0 during the horizontal blank and throughout lines 480..524.
- rgb_in = {pixel_x[7:0],pixel_y[7:0],8'h5A} -> at each pix_en edge, VGA_R/G equal the coordinate presented on the previous pix_en edge; VGA_B=5A in active area.
- Assert reset at pixel_x=300, pixel_y=200 -> outputs return to reset values within the same cycle (async); after release, counting restarts at (0,0) and frame_start pulses.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing from a 50 MHz clock: divide-by-2 pixel enable, h/v counters,
// coordinate output to the colour logic and registered ADV7123 DAC pin drive.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [23:0] rgb_in,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic        div_q;
  logic        pix_en;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        active;
  logic        hs_q, hs_d, vs_q, vs_d, blank_n_q;
  logic [23:0] rgb_q, rgb_d;

  assign pix_en = div_q;
  assign active = (h_q < H_ACT) && (v_q < V_ACT);

  always_comb begin
    h_d   = h_q;
    v_d   = v_q;
    hs_d  = ~((h_q >= HS_BEG) && (h_q < HS_END));
    vs_d  = ~((v_q >= VS_BEG) && (v_q < VS_END));
    rgb_d = active ? rgb_in : 24'h0;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Pins load only on pixel-enable edges, so they trail the presented count by one pixel.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div_q     <= 1'b0;
      h_q       <= 10'd0;
      v_q       <= 10'd0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= 24'h0;
    end else begin
      div_q <= ~div_q;
      h_q   <= h_d;
      v_q   <= v_d;
      if (pix_en) begin
        hs_q      <= hs_d;
        vs_q      <= vs_d;
        blank_n_q <= active;
        rgb_q     <= rgb_d;
      end
    end
  end

  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign pixel_valid = active;
  assign frame_start = pix_en && (h_q == 10'd0) && (v_q == 10'd0);
  // div_q is itself a register; the DAC samples on its rising edge, mid-way through each pixel.
  assign VGA_CLK     = div_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance and a shrunken-timing instance share stimulus,
// both compared every cycle against an arithmetic model indexed by clock edges since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x, y;
    logic        pv, fs, vclk, hs, vs, bn, sn;
    logic [23:0] rgb;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] rgb;

  logic [9:0] b_px, b_py, s_px, s_py;
  logic       b_pv, b_fs, b_clk, b_hs, b_vs, b_bn, b_sn;
  logic       s_pv, s_fs, s_clk, s_hs, s_vs, s_bn, s_sn;
  logic [7:0] b_r, b_g, b_b, s_r, s_g, s_b;
  obs_t       ob_big, ob_small;

  int checks = 0;
  int errors = 0;
  int k;
  int mode;
  logic [23:0] rgb_lat;
  int hs_fall, vs_fall, fs_cnt;
  logic hs_prev, vs_prev;

  always #10 clk = ~clk;

  vga_timing_gen u_big (
    .CLOCK_50(clk), .reset(reset), .rgb_in(rgb),
    .pixel_x(b_px), .pixel_y(b_py), .pixel_valid(b_pv), .frame_start(b_fs),
    .VGA_CLK(b_clk), .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn),
    .VGA_SYNC_N(b_sn), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .CLOCK_50(clk), .reset(reset), .rgb_in(rgb),
    .pixel_x(s_px), .pixel_y(s_py), .pixel_valid(s_pv), .frame_start(s_fs),
    .VGA_CLK(s_clk), .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bn),
    .VGA_SYNC_N(s_sn), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b)
  );

  assign ob_big   = {b_px, b_py, b_pv, b_fs, b_clk, b_hs, b_vs, b_bn, b_sn, b_r, b_g, b_b};
  assign ob_small = {s_px, s_py, s_pv, s_fs, s_clk, s_hs, s_vs, s_bn, s_sn, s_r, s_g, s_b};

  // Expected outputs after k clock edges since reset release: the count is floor(k/2)
  // pixels into the frame; pins show the pixel before that, with the colour sampled then.
  function automatic obs_t model(input int kk, input int ha, input int hf, input int hsw,
                                 input int hb, input int va, input int vf, input int vsw,
                                 input int vb, input logic [23:0] lat);
    int ht = ha + hf + hsw + hb;
    int vt = va + vf + vsw + vb;
    int n  = kk / 2;
    int h  = n % ht;
    int v  = (n / ht) % vt;
    int hp, vp;
    obs_t o;
    o.x    = 10'(h);
    o.y    = 10'(v);
    o.pv   = (h < ha) && (v < va);
    o.vclk = (kk % 2) == 1;
    o.fs   = ((kk % 2) == 1) && (h == 0) && (v == 0);
    o.sn   = 1'b0;
    if (n == 0) begin
      o.hs = 1'b1; o.vs = 1'b1; o.bn = 1'b0; o.rgb = 24'h0;
    end else begin
      hp    = (n - 1) % ht;
      vp    = ((n - 1) / ht) % vt;
      o.hs  = !((hp >= ha + hf) && (hp < ha + hf + hsw));
      o.vs  = !((vp >= va + vf) && (vp < va + vf + vsw));
      o.bn  = (hp < ha) && (vp < va);
      o.rgb = o.bn ? lat : 24'h0;
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h k=%0d", tag, got, exp, k);
    end
  endtask

  task automatic check_all(input string tag);
    obs_t eb, es;
    eb = model(k, 640, 16, 96, 48, 480, 10, 2, 33, rgb_lat);
    es = model(k, 16, 4, 6, 5, 8, 2, 2, 3, rgb_lat);
    check({tag, "_big"}, 64'(ob_big), 64'(eb));
    check({tag, "_small"}, 64'(ob_small), 64'(es));
  endtask

  task automatic restart_tracking();
    k = 0; hs_fall = -1; vs_fall = -1; fs_cnt = 0; hs_prev = 1'b1; vs_prev = 1'b1;
  endtask

  task automatic drive_rgb();
    case (mode)
      0:       rgb = 24'($urandom);
      1:       rgb = 24'hFF0000;
      default: rgb = {b_px[7:0], b_py[7:0], 8'h5A};
    endcase
  endtask

  // Each iteration: edge, model update, check at +1, new stimulus at +3.
  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      k++;
      if (k % 2 == 0) rgb_lat = rgb;
      #1;
      check_all(tag);
      if (hs_prev && !b_hs) begin
        if (hs_fall < 0) check("big_hs_first_fall", 64'(k), 64'd1314);
        else             check("big_hs_period", 64'(k - hs_fall), 64'd1600);
        hs_fall = k;
      end
      if (!hs_prev && b_hs && hs_fall >= 0) check("big_hs_low", 64'(k - hs_fall), 64'd192);
      if (vs_prev && !s_vs) begin
        if (vs_fall >= 0) check("small_vs_period", 64'(k - vs_fall), 64'd930);
        vs_fall = k;
      end
      if (!vs_prev && s_vs && vs_fall >= 0) check("small_vs_low", 64'(k - vs_fall), 64'd124);
      hs_prev = b_hs;
      vs_prev = s_vs;
      if (s_fs) fs_cnt++;
      #2;
      drive_rgb();
    end
  endtask

  task automatic check_frames(input string tag);
    check(tag, 64'(fs_cnt), 64'((k - 1) / 930 + 1));
  endtask

  // Called at +3 after an edge: async reset must clear everything before the next edge.
  task automatic mid_reset(input string tag);
    reset = 1'b1;
    restart_tracking();
    #1;
    check_all({tag, "_async"});
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all({tag, "_held"});
    end
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    rgb     = 24'h0;
    rgb_lat = 24'h0;
    mode    = 0;
    restart_tracking();
    repeat (5) begin
      @(posedge clk);
      #1;
      check_all("reset");
    end
    #2;
    reset = 1'b0;

    run(2200, "rand");
    check_frames("small_frame_starts_rand");

    mid_reset("midrst");
    mode = 1;
    drive_rgb();
    run(2000, "red");
    mode = 2;
    drive_rgb();
    run(2000, "coord");
    check_frames("small_frame_starts_long");

    mid_reset("midrst2");
    mode = 0;
    run(40, "after_rst2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
